hex_bcd_digit_driver: RTL and testbench
=======================================

Name: hex_bcd_digit_driver

Overview:
- Upstream stage of the seven-segment decoder.
- Accepts a 32-bit value written by the LSU output-peripheral path and produces eight display digit codes, io_hex0_o..io_hex7_o, which the decoder consumes directly.
- Two modes: raw hex nibbles (single cycle) or unsigned decimal, converted by an iterative double-dabble over 32 cycles.
- Values too large for eight decimal digits are flagged as overflow and shown as all-E.

Parameters:
- DATA_W, 32, width of the written value; the shift counter counts DATA_W iterations.
- NUM_DIGITS, 8, number of digit outputs. Fixed at 8; other values are unsupported.
- DEC_MAX, 99999999, largest value displayable in decimal mode.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_wr_en  input  1  write strobe; accepted only when o_busy=0.
- i_wr_data  input  DATA_W  value to display.
- i_mode  input  1  0 = hex display, 1 = unsigned decimal display; sampled with the write.
- o_busy  output  1  high while a decimal conversion is in progress.
- o_done  output  1  one-cycle pulse: new digits are valid on the io_hex*_o outputs.
- o_ovf  output  1  last accepted decimal write exceeded DEC_MAX.
- io_hex0_o..io_hex7_o  output  7 each  digit codes formatted as {3'b000, nibble}; io_hex0_o is the least significant digit.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - All io_hex*_o = 7'h00; o_busy = 0, o_done = 0, o_ovf = 0; state = IDLE.
  - Any conversion in progress is aborted; its result is never loaded.
  - Reset has priority over every other event.
- States: IDLE, SHIFT, DONE. o_busy = (state != IDLE), registered.
- Accept: at rising edge k with state=IDLE, i_wr_en=1, i_rst=0.
  - Writes with o_busy=1 are silently dropped; they cause no state change and no o_done pulse.
- Hex mode (i_mode=0):
  - At edge k, digit n takes i_wr_data[4n+3:4n]; o_ovf is cleared.
  - o_done=1 for the cycle after edge k.
  - State stays IDLE; o_busy never rises.
- Decimal overflow (i_mode=1, i_wr_data > DEC_MAX, compared as unsigned):
  - At edge k, all digits = 7'h0E and o_ovf is set.
  - o_done=1 for the next cycle; state stays IDLE.
- Decimal conversion (i_mode=1, i_wr_data <= DEC_MAX):
  - Edge k: load shift register = i_wr_data, BCD register = 0, counter = 0; o_ovf is cleared; state -> SHIFT.
  - Edges k+1..k+32, one iteration each:
    - Add 3 to every BCD nibble that is >= 5.
    - Shift {BCD, shift register} left by 1.
    - Increment the counter.
  - Edge k+32: the counter reaches DATA_W-1 -> state DONE.
  - Edge k+33: BCD register -> io_hex*_o; state -> IDLE.
  - o_done=1 during the cycle after edge k+33; o_busy=0 from that cycle.
  - Total latency from accept to valid digits: 33 edges.
- io_hex*_o hold their previous values throughout a conversion; no partial results are ever visible.
- The BCD register is 32 bits. Because the value is <= DEC_MAX, no digit exceeds 9 and no bit carries out of the register.
- o_done is asserted only for the single cycle described in each mode above.
- A write accepted in the same cycle o_done is high is legal and starts a new operation.
- o_ovf holds until the next accepted write or reset.
- i_wr_data and i_mode are sampled only at accept; later changes have no effect.

Test Plan:
- Reset, then hex write 0x1234ABCD -> next cycle digits 7..0 = 1,2,3,4,A,B,C,D (io_hex0_o = 7'h0D); o_done pulses once; o_busy stays 0.
- Decimal write 12345678 -> o_busy high for exactly 33 cycles; o_done pulses 34 cycles after accept; digits 7..0 = 1,2,3,4,5,6,7,8; o_ovf = 0.
- Decimal writes 99999999 then 100000000:
  - First -> all digits 9, o_ovf = 0.
  - Second -> all digits 7'h0E, o_ovf = 1 after a single cycle.
  - A following hex write 0 -> o_ovf clears, all digits 0.
- Decimal write 0, plus a second write while o_busy = 1:
  - The second write is dropped.
  - Result digits are all 0; only one o_done pulse occurs.
  - Previous digits are unchanged until the DONE edge.
- Assert i_rst for one cycle 10 cycles into a decimal conversion of 87654321 -> digits 7'h00, o_busy = 0; no o_done pulse follows.
- Back-to-back case: issue a decimal write 42 in the o_done cycle of the previous operation -> it is accepted, and the digits read 00000042 after a further 33 edges.

Source files
------------

// File: rtl/hex_bcd_digit_driver.sv
// Eight-digit display driver: shows a written value as raw hex nibbles or, via an
// iterative double-dabble, as unsigned decimal with an all-E overflow indication.
module hex_bcd_digit_driver #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8,
  parameter int DEC_MAX    = 99999999
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic [1:0]        o_state,
  output logic [6:0]        io_hex0_o,
  output logic [6:0]        io_hex1_o,
  output logic [6:0]        io_hex2_o,
  output logic [6:0]        io_hex3_o,
  output logic [6:0]        io_hex4_o,
  output logic [6:0]        io_hex5_o,
  output logic [6:0]        io_hex6_o,
  output logic [6:0]        io_hex7_o
);

  // Handshake: a write is taken on a rising edge where i_wr_en=1 and o_busy=0;
  // writes while busy are dropped. o_done pulses one cycle when new digits are shown.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                CNT_W     = $clog2(DATA_W);
  localparam int                BCD_W     = 4 * NUM_DIGITS;
  localparam logic [DATA_W-1:0] DEC_MAX_V = DATA_W'(DEC_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sr;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [6:0]         hex_q [NUM_DIGITS];

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_ovf  <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
      bcd    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= 7'h00;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wr_en) begin
            if (!i_mode) begin
              for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= {3'b000, i_wr_data[4*i +: 4]};
              o_ovf  <= 1'b0;
              o_done <= 1'b1;
            end else if (i_wr_data > DEC_MAX_V) begin
              for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= 7'h0E;
              o_ovf  <= 1'b1;
              o_done <= 1'b1;
            end else begin
              sr     <= i_wr_data;
              bcd    <= '0;
              cnt    <= '0;
              o_ovf  <= 1'b0;
              o_busy <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[BCD_W-2:0], sr[DATA_W-1]};
          sr  <= {sr[DATA_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          // Digits change only here so a conversion never shows partial results.
          for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= {3'b000, bcd[4*i +: 4]};
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign o_state   = state;
  assign io_hex0_o = hex_q[0];
  assign io_hex1_o = hex_q[1];
  assign io_hex2_o = hex_q[2];
  assign io_hex3_o = hex_q[3];
  assign io_hex4_o = hex_q[4];
  assign io_hex5_o = hex_q[5];
  assign io_hex6_o = hex_q[6];
  assign io_hex7_o = hex_q[7];

endmodule

// File: tb/tb_hex_bcd_digit_driver.sv
// Directed bench for hex_bcd_digit_driver: hex, decimal, overflow, dropped
// writes, mid-conversion reset and back-to-back accept.
module tb_hex_bcd_digit_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        mode;
  logic        busy, done, ovf;
  logic [1:0]  state;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int checks = 0;
  int errors = 0;

  hex_bcd_digit_driver dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_mode    (mode),
    .o_busy    (busy),
    .o_done    (done),
    .o_ovf     (ovf),
    .o_state   (state),
    .io_hex0_o (hex0),
    .io_hex1_o (hex1),
    .io_hex2_o (hex2),
    .io_hex3_o (hex3),
    .io_hex4_o (hex4),
    .io_hex5_o (hex5),
    .io_hex6_o (hex6),
    .io_hex7_o (hex7)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] nibs();
    return {hex7[3:0], hex6[3:0], hex5[3:0], hex4[3:0],
            hex3[3:0], hex2[3:0], hex1[3:0], hex0[3:0]};
  endfunction

  function automatic logic [23:0] his();
    return {hex7[6:4], hex6[6:4], hex5[6:4], hex4[6:4],
            hex3[6:4], hex2[6:4], hex1[6:4], hex0[6:4]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_digits(input string tag, input logic [31:0] exp);
    check({tag, "_nib"}, nibs(), exp);
    check({tag, "_hi"}, {8'h0, his()}, 32'h0);
  endtask

  // driver: one write strobe, returns 1ns after the accepting edge
  task automatic write(input logic m, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    mode    = m;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_data = $urandom;
  endtask

  // Steps until o_done, bounded; reports edges taken, busy samples, and whether
  // digits moved before done.
  task automatic wait_done(output int edges, output int busy_cyc, output bit changed);
    logic [31:0] snap;
    snap     = nibs();
    edges    = 0;
    busy_cyc = 0;
    changed  = 1'b0;
    while (!done && edges < 100) begin
      if (busy) busy_cyc++;
      if (nibs() !== snap) changed = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  int  edges, bcyc, pulses;
  bit  changed;

  initial begin
    rst = 1'b1; wr_en = 1'b0; mode = 1'b0; wr_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_digits("reset_digits", 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_ovf", {31'b0, ovf}, 32'd0);
    check("reset_state", {30'b0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // hex write
    write(1'b0, 32'h1234ABCD);
    check_digits("hex_digits", 32'h1234ABCD);
    check("hex_done", {31'b0, done}, 32'd1);
    check("hex_busy", {31'b0, busy}, 32'd0);
    check("hex_ovf", {31'b0, ovf}, 32'd0);
    count_done(3, pulses);
    check("hex_single_pulse", pulses, 32'd0);
    check("hex_busy_after", {31'b0, busy}, 32'd0);

    // decimal 12345678
    write(1'b1, 32'd12345678);
    check("dec_busy_start", {31'b0, busy}, 32'd1);
    wait_done(edges, bcyc, changed);
    check("dec_latency", edges, 32'd33);
    check("dec_busy_cycles", bcyc, 32'd33);
    check("dec_no_partial", {31'b0, changed}, 32'd0);
    check_digits("dec_digits", 32'h12345678);
    check("dec_ovf", {31'b0, ovf}, 32'd0);
    check("dec_busy_at_done", {31'b0, busy}, 32'd0);
    count_done(1, pulses);
    check("dec_single_pulse", pulses, 32'd0);

    // decimal 0 with a write dropped while busy
    write(1'b1, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    wr_en = 1'b1; mode = 1'b0; wr_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check_digits("drop_hold", 32'h12345678);
    check("drop_busy", {31'b0, busy}, 32'd1);
    wait_done(edges, bcyc, changed);
    check("drop_latency", edges, 32'd27);
    check("drop_no_partial", {31'b0, changed}, 32'd0);
    check_digits("zero_digits", 32'h0);
    count_done(40, pulses);
    check("drop_no_extra_done", pulses, 32'd0);

    // decimal max and overflow
    write(1'b1, 32'd99999999);
    wait_done(edges, bcyc, changed);
    check("max_latency", edges, 32'd33);
    check_digits("max_digits", 32'h99999999);
    check("max_ovf", {31'b0, ovf}, 32'd0);

    write(1'b1, 32'd100000000);
    check("ovf_done", {31'b0, done}, 32'd1);
    check("ovf_flag", {31'b0, ovf}, 32'd1);
    check("ovf_busy", {31'b0, busy}, 32'd0);
    check_digits("ovf_digits", 32'hEEEEEEEE);
    count_done(2, pulses);
    check("ovf_single_pulse", pulses, 32'd0);
    check("ovf_hold", {31'b0, ovf}, 32'd1);

    write(1'b0, 32'h0);
    check("ovf_clear", {31'b0, ovf}, 32'd0);
    check_digits("hex_zero", 32'h0);

    // reset ten cycles into a conversion
    write(1'b0, 32'hCAFEF00D);
    check_digits("pre_rst_digits", 32'hCAFEF00D);
    write(1'b1, 32'd87654321);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_digits("rst_mid_digits", 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_state", {30'b0, state}, 32'd0);
    count_done(40, pulses);
    check("rst_mid_no_done", pulses, 32'd0);
    check_digits("rst_mid_after", 32'h0);

    // back-to-back: decimal write accepted in the done cycle of a hex write
    write(1'b0, 32'hDEADBEEF);
    check("b2b_done", {31'b0, done}, 32'd1);
    wr_en = 1'b1; mode = 1'b1; wr_data = 32'd42;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("b2b_accept", {31'b0, busy}, 32'd1);
    wait_done(edges, bcyc, changed);
    check("b2b_latency", edges, 32'd33);
    check_digits("b2b_digits", 32'h00000042);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
